// File: rtl/lock_reset_seq_pkg.sv
// Shared types for the lock-driven reset sequencer.
// The state encoding is also what the debug/LED port exposes.
package lock_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } lock_state_t;

endpackage

// File: rtl/lock_reset_seq_sync_ff.sv
// Generic multi-stage synchroniser for a single asynchronous bit.
// Every stage clears asynchronously, so the output is 0 while in reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the sampled input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/lock_reset_seq.sv
// Holds a downstream reset until the clock generator has been locked for a stable
// window plus a fixed hold time; any loss of lock or forced restart re-arms the sequence.
module lock_reset_seq
    import lock_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int RST_HOLD_CYC    = 16,
    parameter int LOSS_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked_async,
    input  logic                  force_rst_async,
    input  logic                  clr_loss,
    output logic                  rst_out_n,
    output logic                  ready,
    output logic                  lock_s,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic [STATE_W-1:0]    state_dbg
);

    localparam int CNT_MAX = (LOCK_STABLE_CYC > RST_HOLD_CYC) ? LOCK_STABLE_CYC : RST_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = {LOSS_CNT_W{1'b1}};
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE  = LOSS_CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_ZERO = {LOSS_CNT_W{1'b0}};

    lock_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  run_q;
    logic                  force_s;
    logic                  loss_evt_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked_async),
        .q     (lock_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_force (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (force_rst_async),
        .q     (force_s)
    );

    // Next-state, window counter and loss counter; a forced restart wins over every transition.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_evt_s = (state_q == RUN) && !lock_s;

        if (force_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABILIZE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STAB_LAST) begin
                        state_d = HOLD;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        // A clear coinciding with a loss still records that loss.
        if (loss_evt_s) begin
            if (clr_loss) begin
                loss_d = LOSS_ONE;
            end else if (loss_q == LOSS_MAX) begin
                loss_d = loss_q;
            end else begin
                loss_d = loss_q + LOSS_ONE;
            end
        end else if (clr_loss) begin
            loss_d = LOSS_ZERO;
        end else begin
            loss_d = loss_q;
        end
    end

    // State, counters and the registered downstream reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= CNT_ZERO;
            loss_q  <= LOSS_ZERO;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign rst_out_n  = run_q;
    assign ready      = run_q;
    assign loss_count = loss_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_lock_reset_seq.sv
// Directed and randomised checks of lock_reset_seq against a run-length reference model:
// the expected state follows from how many consecutive edges saw lock high without force.
module tb_lock_reset_seq;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;
    localparam int LW   = 2;
    localparam int LMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          locked_async;
    logic          force_rst_async;
    logic          clr_loss;
    logic          rst_out_n;
    logic          ready;
    logic          lock_s;
    logic [LW-1:0] loss_count;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: synchroniser delay lines plus a count of qualifying edges.
    logic lp [0:SYNC-1];
    logic fp [0:SYNC-1];
    int   m_up;
    int   m_loss;

    lock_reset_seq #(
        .SYNC_STAGES     (SYNC),
        .LOCK_STABLE_CYC (LSC),
        .RST_HOLD_CYC    (RHC),
        .LOSS_CNT_W      (LW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .locked_async    (locked_async),
        .force_rst_async (force_rst_async),
        .clr_loss        (clr_loss),
        .rst_out_n       (rst_out_n),
        .ready           (ready),
        .lock_s          (lock_s),
        .loss_count      (loss_count),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic int m_state(input int up);
        if (up == 0)              return 0;
        else if (up < 1 + LSC)       return 1;
        else if (up < 1 + LSC + RHC) return 2;
        else                         return 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) begin
            lp[i] = 1'b0;
            fp[i] = 1'b0;
        end
        m_up   = 0;
        m_loss = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int st;
        st = m_state(m_up);
        chk({tag, ".state"}, 8'(state_dbg), 8'(st));
        chk({tag, ".rst_out_n"}, 8'(rst_out_n), 8'(st == 3));
        chk({tag, ".ready"}, 8'(ready), 8'(st == 3));
        chk({tag, ".lock_s"}, 8'(lock_s), 8'(lp[SYNC-1]));
        chk({tag, ".loss"}, 8'(loss_count), 8'(m_loss));
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic tick(input string tag);
        logic ls_pre;
        logic fs_pre;
        int   st_pre;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            ls_pre = lp[SYNC-1];
            fs_pre = fp[SYNC-1];
            st_pre = m_state(m_up);
            for (int i = SYNC - 1; i > 0; i--) begin
                lp[i] = lp[i-1];
                fp[i] = fp[i-1];
            end
            lp[0] = locked_async;
            fp[0] = force_rst_async;
            if (st_pre == 3 && !ls_pre)
                m_loss = clr_loss ? 1 : ((m_loss == LMAX) ? LMAX : m_loss + 1);
            else if (clr_loss)
                m_loss = 0;
            if (fs_pre || !ls_pre) m_up = 0;
            else if (m_up < 1000)  m_up = m_up + 1;
        end
        #1;
        check_model(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rst_out_n"}, 8'(rst_out_n), 8'd0);
        chk({tag, ".ready"}, 8'(ready), 8'd0);
        chk({tag, ".lock_s"}, 8'(lock_s), 8'd0);
        chk({tag, ".loss"}, 8'(loss_count), 8'd0);
        chk({tag, ".state"}, 8'(state_dbg), 8'd0);
    endtask

    // Relock from WAIT_LOCK: rst_out_n must rise exactly at edge SYNC+LSC+RHC.
    task automatic relock(input string tag);
        locked_async = 1'b1;
        for (int e = 0; e <= SYNC + LSC + RHC; e++) begin
            tick(tag);
            chk({tag, ".rise_edge"}, 8'(rst_out_n), 8'(e == SYNC + LSC + RHC));
        end
    endtask

    task automatic drop_in_run(input string tag);
        locked_async = 1'b0;
        for (int e = 0; e <= SYNC; e++) begin
            tick(tag);
            chk({tag, ".fall_edge"}, 8'(rst_out_n), 8'(e < SYNC));
        end
    endtask

    initial begin
        int exp_st;
        int len;
        rst_n           = 1'b0;
        locked_async    = 1'b0;
        force_rst_async = 1'b0;
        clr_loss        = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("reset");

        // Power-up with lock present from the first edge after reset release.
        repeat (3) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        locked_async = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            tick("powerup");
            exp_st = (e < 2) ? 0 : (e < 10) ? 1 : (e < 14) ? 2 : 3;
            chk("powerup.edge_state", 8'(state_dbg), 8'(exp_st));
        end

        // Lock drop in RUN, then relock.
        drop_in_run("drop_run");
        chk("drop_run.loss", 8'(loss_count), 8'd1);
        relock("relock");

        // Drop during the stabilise window: no loss, full window restarts.
        drop_in_run("pre_stab");
        locked_async = 1'b1;
        repeat (7) tick("stab");
        chk("stab.in_stab", 8'(state_dbg), 8'd1);
        locked_async = 1'b0;
        repeat (3) tick("stab_drop");
        chk("stab_drop.state", 8'(state_dbg), 8'd0);
        chk("stab_drop.loss", 8'(loss_count), 8'd2);
        relock("stab_restart");

        // Saturation of the loss counter, then clear coincident with a loss.
        clr_loss = 1'b1;
        tick("clr");
        clr_loss = 1'b0;
        chk("clr.loss", 8'(loss_count), 8'd0);
        for (int i = 1; i <= 5; i++) begin
            drop_in_run("sat_drop");
            chk("sat.loss", 8'(loss_count), 8'((i < 3) ? i : 3));
            relock("sat_relock");
        end
        locked_async = 1'b0;
        tick("clr_loss_evt");
        tick("clr_loss_evt");
        clr_loss = 1'b1;
        tick("clr_loss_evt");
        clr_loss = 1'b0;
        chk("clr_loss_evt.loss", 8'(loss_count), 8'd1);
        relock("after_clr");

        // Forced restart held for 10 cycles while in RUN.
        force_rst_async = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick("force");
            chk("force.rst_out_n", 8'(rst_out_n), 8'(e < 2));
        end
        chk("force.loss", 8'(loss_count), 8'd1);
        force_rst_async = 1'b0;
        for (int e = 0; e <= 14; e++) begin
            tick("force_rel");
            chk("force_rel.rise_edge", 8'(rst_out_n), 8'(e == 14));
        end

        // Asynchronous reset in the middle of HOLD.
        drop_in_run("pre_hold");
        locked_async = 1'b1;
        repeat (12) tick("to_hold");
        chk("to_hold.state", 8'(state_dbg), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        tick("in_rst");
        tick("in_rst");
        rst_n = 1'b1;
        relock("post_rst");

        // Randomised lock segments with occasional forces, clears and glitches.
        for (int seg = 0; seg < 30; seg++) begin
            len = $urandom_range(1, 25);
            locked_async = 1'b1;
            for (int c = 0; c < len; c++) begin
                clr_loss = ($urandom_range(0, 29) == 0);
                tick("rand_hi");
            end
            clr_loss        = ($urandom_range(0, 3) == 0);
            force_rst_async = (seg % 4 == 0);
            locked_async    = 1'b0;
            len = $urandom_range(1, 3);
            for (int c = 0; c < len; c++) begin
                tick("rand_lo");
                clr_loss = 1'b0;
            end
            force_rst_async = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
